// File: rtl/sar_search.sv
// Successive-approximation search: binary-searches a WIDTH-bit target using an external comparator.
// Optional macro SAR_FLAG_CHECK_EN ends a search with error=1 when comparator flags are not one-hot.
module sar_search #(
    parameter int WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          equal,
    input  logic                          lower,
    input  logic                          greater,
    output logic [WIDTH-1:0]              guess,
    output logic                          busy,
    output logic                          done,
    output logic                          found,
    output logic [WIDTH-1:0]              result,
    output logic [$clog2(WIDTH+2)-1:0]    steps,
    output logic                          error
);

    localparam int SW = $clog2(WIDTH+2);
    localparam logic [WIDTH:0]  OneExt = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0]  MaxExt = {1'b0, {WIDTH{1'b1}}};
    localparam logic [SW-1:0]   OneSteps = {{(SW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StProbe, StDone} state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH:0]     r_lo, r_hi, w_lo_nxt, w_hi_nxt;
    logic [WIDTH-1:0]   r_guess, w_guess_nxt;
    logic [WIDTH-1:0]   r_result, w_result_nxt;
    logic               r_found, w_found_nxt;
    logic               r_error, w_error_nxt;
    logic [SW-1:0]      r_steps, w_steps_nxt;
    logic [WIDTH+1:0]   w_sum;
    logic [WIDTH:0]     w_guess_ext;
    logic               w_bad_flags;
    logic               w_empty;

`ifdef SAR_FLAG_CHECK_EN
    always_comb begin
        unique case ({equal, lower, greater})
            3'b100, 3'b010, 3'b001: w_bad_flags = 1'b0;
            default:                w_bad_flags = 1'b1;
        endcase
    end
`else
    assign w_bad_flags = 1'b0;
`endif

    assign w_guess_ext = {1'b0, r_guess};

    always_comb begin
        w_state_nxt  = r_state;
        w_lo_nxt     = r_lo;
        w_hi_nxt     = r_hi;
        w_guess_nxt  = r_guess;
        w_result_nxt = r_result;
        w_found_nxt  = r_found;
        w_error_nxt  = r_error;
        w_steps_nxt  = r_steps;
        w_sum        = '0;
        w_empty      = 1'b0;
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_lo_nxt    = '0;
                    w_hi_nxt    = MaxExt;
                    w_sum       = {2'b00, MaxExt[WIDTH-1:0]};
                    w_guess_nxt = w_sum[WIDTH:1];
                    w_steps_nxt = '0;
                    w_found_nxt = 1'b0;
                    w_error_nxt = 1'b0;
                    w_state_nxt = StProbe;
                end
            end
            StProbe: begin
                w_steps_nxt = r_steps + OneSteps;
                if (w_bad_flags) begin
                    w_error_nxt = 1'b1;
                    w_found_nxt = 1'b0;
                    w_state_nxt = StDone;
                end else if (equal) begin
                    w_found_nxt  = 1'b1;
                    w_result_nxt = r_guess;
                    w_state_nxt  = StDone;
                end else begin
                    // Empty-range test is done before the subtract so hi never holds a wrapped value.
                    w_empty = lower ? ((w_guess_ext + OneExt) > r_hi) : (w_guess_ext <= r_lo);
                    if (w_empty) begin
                        w_found_nxt = 1'b0;
                        w_state_nxt = StDone;
                    end else begin
                        if (lower) w_lo_nxt = w_guess_ext + OneExt;
                        else       w_hi_nxt = w_guess_ext - OneExt;
                        w_sum       = {1'b0, w_lo_nxt} + {1'b0, w_hi_nxt};
                        w_guess_nxt = w_sum[WIDTH:1];
                    end
                end
            end
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_lo     <= '0;
            r_hi     <= '0;
            r_guess  <= '0;
            r_result <= '0;
            r_found  <= 1'b0;
            r_error  <= 1'b0;
            r_steps  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_lo     <= w_lo_nxt;
            r_hi     <= w_hi_nxt;
            r_guess  <= w_guess_nxt;
            r_result <= w_result_nxt;
            r_found  <= w_found_nxt;
            r_error  <= w_error_nxt;
            r_steps  <= w_steps_nxt;
        end
    end

    assign guess  = r_guess;
    assign result = r_result;
    assign found  = r_found;
    assign error  = r_error;
    assign steps  = r_steps;
    assign busy   = (r_state == StProbe);
    assign done   = (r_state == StDone);

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search (WIDTH=4): vector table, corner sequences and random targets
// against a plain-arithmetic binary-search model.
module tb_sar_search;

    localparam int W  = 4;
    localparam int SW = $clog2(W+2);
`ifdef SAR_FLAG_CHECK_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, equal, lower, greater;
    logic [W-1:0]  guess, result;
    logic          busy, done, found, error;
    logic [SW-1:0] steps;

    sar_search #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .equal(equal), .lower(lower), .greater(greater),
        .guess(guess), .busy(busy), .done(done), .found(found), .result(result),
        .steps(steps), .error(error)
    );

    always #5 clk = ~clk;

    // Comparator: mode 0 normal, 1 always "lower", 2 all-zero flags on the first probe.
    int target = 0;
    int mode   = 0;
    bit first_probe = 1'b0;
    always_comb begin
        equal = 1'b0; lower = 1'b0; greater = 1'b0;
        if (mode == 1) lower = 1'b1;
        else if (!(mode == 2 && first_probe)) begin
            equal   = (int'(guess) == target);
            lower   = (int'(guess) <  target);
            greater = (int'(guess) >  target);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Reference model: textbook binary search over integers.
    int exp_g[$];
    int m_found, m_result, m_steps, m_err;
    function automatic void model(int tgt, int md);
        int lo, hi, g;
        bit eq, lt, gt, first;
        exp_g.delete();
        lo = 0; hi = (1 << W) - 1;
        m_found = 0; m_result = 0; m_steps = 0; m_err = 0; first = 1;
        forever begin
            g = (lo + hi) / 2;
            exp_g.push_back(g);
            m_steps++;
            if (md == 1)                 begin eq = 0; lt = 1; gt = 0; end
            else if (md == 2 && first)   begin eq = 0; lt = 0; gt = 0; end
            else begin eq = (g == tgt); lt = (g < tgt); gt = (g > tgt); end
            first = 0;
            if (ChkEn && (int'(eq) + int'(lt) + int'(gt)) != 1) begin m_err = 1; break; end
            if (eq) begin m_found = 1; m_result = g; break; end
            if (lt) lo = g + 1;
            else    hi = g - 1;
            if (lo > hi) break;
        end
    endfunction

    int seen_g[$];
    int lat;
    int s_found, s_result, s_steps, s_err;

    task automatic run_search(input int tgt, input int md);
        target = tgt; mode = md; seen_g.delete();
        @(negedge clk); start = 1'b1; first_probe = 1'b1;
        @(negedge clk); start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            if (busy) seen_g.push_back(int'(guess));
            @(negedge clk);
            first_probe = 1'b0;
            lat++;
        end
        check("done within bound", int'(done), 1);
        s_found = int'(found); s_result = int'(result); s_steps = int'(steps); s_err = int'(error);
        @(negedge clk);
        check("done one-cycle pulse", int'(done), 0);
    endtask

    task automatic verify(string tag, int tgt, int md);
        int bad;
        model(tgt, md);
        run_search(tgt, md);
        check({tag, " steps"}, s_steps, m_steps);
        check({tag, " found"}, s_found, m_found);
        if (m_found != 0) check({tag, " result"}, s_result, m_result);
        check({tag, " error"}, s_err, m_err);
        check({tag, " latency"}, lat, m_steps + 1);
        check({tag, " probe count"}, seen_g.size(), exp_g.size());
        bad = 0;
        for (int i = 0; i < seen_g.size() && i < exp_g.size(); i++)
            if (seen_g[i] != exp_g[i]) bad++;
        check({tag, " guess sequence errors"}, bad, 0);
    endtask

    typedef struct {
        int tgt; int md; int e_found; int e_result; int e_steps;
    } vec_t;
    vec_t vecs[6];

    initial begin
        vecs[0] = '{7, 0, 1, 7, 1};
        vecs[1] = '{0, 0, 1, 0, 4};
        vecs[2] = '{15, 0, 1, 15, 5};
        vecs[3] = '{10, 0, 1, 10, 4};
        vecs[4] = '{3, 0, 1, 3, 2};
        vecs[5] = '{9, 1, 0, 0, 5};

        rst = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        check("reset guess", int'(guess), 0);
        check("reset result", int'(result), 0);
        check("reset steps", int'(steps), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset found", int'(found), 0);
        check("reset error", int'(error), 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            verify($sformatf("vec%0d", i), vecs[i].tgt, vecs[i].md);
            check($sformatf("vec%0d table found", i), s_found, vecs[i].e_found);
            if (vecs[i].e_found != 0)
                check($sformatf("vec%0d table result", i), s_result, vecs[i].e_result);
            check($sformatf("vec%0d table steps", i), s_steps, vecs[i].e_steps);
        end

        // Hand-written guess sequences at both ends of the range.
        run_search(0, 0);
        check("t0 probes", seen_g.size(), 4);
        if (seen_g.size() == 4) begin
            check("t0 g0", seen_g[0], 7); check("t0 g1", seen_g[1], 3);
            check("t0 g2", seen_g[2], 1); check("t0 g3", seen_g[3], 0);
        end
        run_search(15, 0);
        check("t15 probes", seen_g.size(), 5);
        if (seen_g.size() == 5) begin
            check("t15 g1", seen_g[1], 11); check("t15 g3", seen_g[3], 14);
            check("t15 g4", seen_g[4], 15);
        end
        repeat (3) @(negedge clk);
        check("idle hold guess", int'(guess), 15);
        check("idle hold result", int'(result), 15);
        check("idle hold found", int'(found), 1);
        check("idle hold steps", int'(steps), 5);

        // Zero flags on the first probe.
        verify("zeroflags", 3, 2);
        if (ChkEn) begin
            check("zeroflags chk error", s_err, 1);
            check("zeroflags chk found", s_found, 0);
            check("zeroflags chk steps", s_steps, 1);
        end else begin
            check("zeroflags greater path next guess", seen_g.size() > 1 ? seen_g[1] : -1, 3);
            check("zeroflags error tied", s_err, 0);
        end

        // Restart during PROBE is ignored; reset mid-search.
        target = 10; mode = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("midrst probe1 guess", int'(guess), 7);
        @(negedge clk); start = 1'b1;
        check("midrst probe2 guess", int'(guess), 11);
        @(negedge clk); start = 1'b0; rst = 1'b1;
        check("midrst restart ignored guess", int'(guess), 9);
        check("midrst restart ignored steps", int'(steps), 2);
        check("midrst still busy", int'(busy), 1);
        @(negedge clk); rst = 1'b0;
        check("midrst guess", int'(guess), 0);
        check("midrst steps", int'(steps), 0);
        check("midrst busy", int'(busy), 0);
        check("midrst done", int'(done), 0);
        check("midrst found", int'(found), 0);
        check("midrst result", int'(result), 0);
        check("midrst error", int'(error), 0);
        verify("after rst", 3, 0);
        check("after rst result", s_result, 3);

        for (int i = 0; i < 20; i++)
            verify($sformatf("rand%0d", i), int'($urandom_range(0, (1 << W) - 1)), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
